// File: rtl/sram_vector_loader.sv
// sram_vector_loader: packs a host byte stream into 16-bit little-endian words
// and writes them to consecutive SRAM addresses through an Avalon-style write master.
`default_nettype none

module sram_vector_loader #(
  parameter logic [19:0] BASE_ADDR = 20'h00000,
  parameter int unsigned MAX_WORDS = 1048576
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic [19:0] address,
  output logic [1:0]  byteenable,
  output logic        write,
  output logic [15:0] writedata,
  input  logic        waitrequest,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [20:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [20:0] MAX_WORDS_C = 21'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [19:0] addr_q, addr_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] wdata_q, wdata_d;
  logic        last_q, last_d;
  logic [20:0] wcount_q, wcount_d;
  logic        in_ready_q, write_q, busy_q, done_q, error_q;

  logic        accept;
  logic [20:0] wcount_inc;

  assign accept     = in_valid & in_ready_q;
  assign wcount_inc = wcount_q + 21'd1;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    last_d   = last_q;
    wcount_d = wcount_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d  = S_LO;
          addr_d   = BASE_ADDR;
          wcount_d = 21'd0;
          last_d   = 1'b0;
        end
      end

      S_LO: begin
        if (accept) begin
          wdata_d[7:0] = in_data;
          if (in_last) begin
            // Odd-length tail: only the low byte lane is written.
            wdata_d[15:8] = 8'h00;
            be_d          = 2'b01;
            last_d        = 1'b1;
            state_d       = S_WR;
          end else begin
            last_d  = 1'b0;
            state_d = S_HI;
          end
        end
      end

      S_HI: begin
        if (accept) begin
          wdata_d[15:8] = in_data;
          be_d          = 2'b11;
          last_d        = in_last;
          state_d       = S_WR;
        end
      end

      S_WR: begin
        if (!waitrequest) begin
          wcount_d = wcount_inc;
          if (last_q) begin
            state_d = S_DONE;
          end else if (wcount_inc == MAX_WORDS_C) begin
            state_d = S_ERR;
          end else begin
            // Natural 20-bit rollover is the only wrap the address can take.
            addr_d  = addr_q + 20'd1;
            state_d = S_LO;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= BASE_ADDR;
      be_q       <= 2'b00;
      wdata_q    <= 16'h0000;
      last_q     <= 1'b0;
      wcount_q   <= 21'd0;
      in_ready_q <= 1'b0;
      write_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      last_q     <= last_d;
      wcount_q   <= wcount_d;
      // Status flags are registered from the next state so they align with state_q.
      in_ready_q <= (state_d == S_LO) || (state_d == S_HI);
      write_q    <= (state_d == S_WR);
      busy_q     <= (state_d == S_LO) || (state_d == S_HI) || (state_d == S_WR);
      done_q     <= (state_d == S_DONE);
      error_q    <= (state_d == S_ERR);
    end
  end

  assign in_ready   = in_ready_q;
  assign address    = addr_q;
  assign byteenable = be_q;
  assign write      = write_q;
  assign writedata  = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = wcount_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_vector_loader.sv
// Directed, table-driven bench for sram_vector_loader (MAX_WORDS=2 so the overflow path is reachable).
`default_nettype none

module tb_sram_vector_loader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic [19:0] address;
  logic [1:0]  byteenable;
  logic        write;
  logic [15:0] writedata;
  logic        waitrequest = 1'b0;
  logic        busy, done, error;
  logic [20:0] word_count;

  int n_checks = 0;
  int n_errors = 0;
  int wr_done  = 0;

  sram_vector_loader #(
    .BASE_ADDR(20'h00000),
    .MAX_WORDS(2)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .address(address),
    .byteenable(byteenable),
    .write(write),
    .writedata(writedata),
    .waitrequest(waitrequest),
    .busy(busy),
    .done(done),
    .error(error),
    .word_count(word_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (write && !waitrequest) wr_done <= wr_done + 1;
  end

  typedef struct {
    logic        st;
    logic [7:0]  d;
    logic        l;
    logic        wr;
    logic [19:0] a;
    logic [15:0] wd;
    logic [1:0]  be;
    logic        fin;
    logic [20:0] wc;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " address"},    32'(address),    32'h0);
    chk({tag, " byteenable"}, 32'(byteenable), 32'h0);
    chk({tag, " writedata"},  32'(writedata),  32'h0);
    chk({tag, " write"},      32'(write),      32'h0);
    chk({tag, " in_ready"},   32'(in_ready),   32'h0);
    chk({tag, " busy"},       32'(busy),       32'h0);
    chk({tag, " done"},       32'(done),       32'h0);
    chk({tag, " error"},      32'(error),      32'h0);
    chk({tag, " word_count"}, 32'(word_count), 32'h0);
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Returns 1 ns after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) chk("in_ready timeout", 32'(in_ready), 32'h1);
    @(posedge clock);
    #1 in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  // Expects a write in progress with waitrequest low; returns after it completes.
  task automatic expect_write(input string nm, input logic [19:0] a, input logic [15:0] wd,
                              input logic [1:0] be);
    chk({nm, " write"},      32'(write),      32'h1);
    chk({nm, " address"},    32'(address),    32'(a));
    chk({nm, " writedata"},  32'(writedata),  32'(wd));
    chk({nm, " byteenable"}, 32'(byteenable), 32'(be));
    @(posedge clock);
    #1;
  endtask

  initial begin
    int c0;

    vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 20'h0, 16'h0000, 2'b00, 1'b0, 21'd0};
    vecs[1]  = '{1'b0, 8'h22, 1'b0, 1'b1, 20'h0, 16'h2211, 2'b11, 1'b0, 21'd0};
    vecs[2]  = '{1'b0, 8'h33, 1'b0, 1'b0, 20'h0, 16'h0000, 2'b00, 1'b0, 21'd0};
    vecs[3]  = '{1'b0, 8'h44, 1'b1, 1'b1, 20'h1, 16'h4433, 2'b11, 1'b1, 21'd2};
    vecs[4]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 20'h0, 16'h0000, 2'b00, 1'b0, 21'd0};
    vecs[5]  = '{1'b0, 8'hBB, 1'b0, 1'b1, 20'h0, 16'hBBAA, 2'b11, 1'b0, 21'd0};
    vecs[6]  = '{1'b0, 8'hCC, 1'b1, 1'b1, 20'h1, 16'h00CC, 2'b01, 1'b1, 21'd2};
    vecs[7]  = '{1'b1, 8'h01, 1'b0, 1'b0, 20'h0, 16'h0000, 2'b00, 1'b0, 21'd0};
    vecs[8]  = '{1'b1, 8'h02, 1'b0, 1'b1, 20'h0, 16'h0201, 2'b11, 1'b0, 21'd0};
    vecs[9]  = '{1'b0, 8'h03, 1'b0, 1'b0, 20'h0, 16'h0000, 2'b00, 1'b0, 21'd0};
    vecs[10] = '{1'b0, 8'h04, 1'b1, 1'b1, 20'h1, 16'h0403, 2'b11, 1'b1, 21'd2};

    repeat (3) @(negedge clock);
    chk_reset_vals("in reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk_reset_vals("after reset");

    // Full words, odd tail, and a start pulse landing in HI (record 8).
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].st) begin
        pulse_start();
        chk($sformatf("v%0d busy after start", i), 32'(busy), 32'h1);
      end
      c0 = wr_done;
      send_byte(vecs[i].d, vecs[i].l);
      if (vecs[i].wr) begin
        expect_write($sformatf("v%0d", i), vecs[i].a, vecs[i].wd, vecs[i].be);
        chk($sformatf("v%0d completions", i), 32'(wr_done - c0), 32'h1);
      end
      if (vecs[i].fin) begin
        chk($sformatf("v%0d done", i),       32'(done),       32'h1);
        chk($sformatf("v%0d busy", i),       32'(busy),       32'h0);
        chk($sformatf("v%0d word_count", i), 32'(word_count), 32'(vecs[i].wc));
      end
    end

    // Write held by waitrequest for 5 edges.
    pulse_start();
    chk("ws done cleared", 32'(done), 32'h0);
    chk("ws count cleared", 32'(word_count), 32'h0);
    waitrequest = 1'b1;
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    c0 = wr_done;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk($sformatf("ws%0d write", k),     32'(write),     32'h1);
      chk($sformatf("ws%0d address", k),   32'(address),   32'h0);
      chk($sformatf("ws%0d writedata", k), 32'(writedata), 32'h6655);
      chk($sformatf("ws%0d in_ready", k),  32'(in_ready),  32'h0);
      if (k == 5) waitrequest = 1'b0;
    end
    @(posedge clock);
    #1;
    chk("ws single completion", 32'(wr_done - c0), 32'h1);
    chk("ws next address", 32'(address), 32'h1);
    chk("ws word_count", 32'(word_count), 32'h1);
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b1);
    expect_write("ws second", 20'h1, 16'h8877, 2'b11);
    chk("ws done", 32'(done), 32'h1);
    chk("ws total completions", 32'(wr_done - c0), 32'h2);

    // Overflow at MAX_WORDS without a last flag.
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    expect_write("ovf w0", 20'h0, 16'h0201, 2'b11);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    expect_write("ovf w1", 20'h1, 16'h0403, 2'b11);
    chk("ovf error", 32'(error), 32'h1);
    chk("ovf busy", 32'(busy), 32'h0);
    chk("ovf done", 32'(done), 32'h0);
    chk("ovf word_count", 32'(word_count), 32'h2);
    c0 = wr_done;
    in_valid = 1'b1;
    in_data  = 8'h05;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk($sformatf("ovf in_ready %0d", k), 32'(in_ready), 32'h0);
    end
    in_valid = 1'b0;
    chk("ovf no extra writes", 32'(wr_done - c0), 32'h0);
    chk("ovf error held", 32'(error), 32'h1);
    chk("ovf count held", 32'(word_count), 32'h2);

    // Asynchronous reset during a stalled second write.
    pulse_start();
    chk("rst error cleared", 32'(error), 32'h0);
    send_byte(8'h9A, 1'b0);
    send_byte(8'hBC, 1'b0);
    expect_write("rst w0", 20'h0, 16'hBC9A, 2'b11);
    waitrequest = 1'b1;
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    @(negedge clock);
    chk("rst write before", 32'(write), 32'h1);
    chk("rst address before", 32'(address), 32'h1);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("mid-write reset");
    @(negedge clock);
    reset_n = 1'b1;
    waitrequest = 1'b0;
    c0 = wr_done;
    repeat (3) @(negedge clock);
    chk("rst idle busy", 32'(busy), 32'h0);
    chk("rst idle write", 32'(write), 32'h0);
    chk("rst no reissue", 32'(wr_done - c0), 32'h0);
    pulse_start();
    send_byte(8'hDE, 1'b0);
    send_byte(8'hF0, 1'b1);
    expect_write("rst reload", 20'h0, 16'hF0DE, 2'b11);
    chk("rst reload done", 32'(done), 32'h1);
    chk("rst reload count", 32'(word_count), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/sram_vector_loader.md
SRAM_VECTOR_LOADER -- requirements
Module: sram_vector_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 20'h00000, first SRAM word address written.
REQ-002 SHALL have parameter MAX_WORDS, default 1048576, maximum words accepted per load.
REQ-003 SHALL have port clock  input  1  single clock for all logic, rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse: begin a new load at BASE_ADDR.
REQ-006 SHALL have ports in_valid  input  1, in_ready  output  1, in_data  input  8, in_last  input  1: byte stream from host, last byte flagged.
REQ-007 SHALL have ports address  output  20, byteenable  output  2, write  output  1, writedata  output  16, waitrequest  input  1: write master into SRAM arbiter SOPC side.
REQ-008 SHALL have ports busy  output  1, done  output  1, error  output  1, word_count  output  21: status.

Function
REQ-009 SHALL implement states IDLE, LO, HI, WR, DONE, ERR.
REQ-010 SHALL transfer a byte only on a rising edge with in_valid and in_ready both high; in_ready high only in LO and HI.
REQ-011 IDLE/DONE/ERR: start -> LO, address=BASE_ADDR, word_count=0, done=0, error=0; start in LO/HI/WR ignored.
REQ-012 LO: accepted byte -> writedata[7:0]; in_last=0 -> HI; in_last=1 -> WR with byteenable=2'b01, writedata[15:8]=8'h00.
REQ-013 HI: accepted byte -> writedata[15:8], byteenable=2'b11, -> WR; last flag captured from in_last.
REQ-014 WR: write=1 with address/byteenable/writedata stable; held while waitrequest=1; write completes on first rising edge with waitrequest=0.
REQ-015 On write completion: word_count+1; if last captured -> DONE; else if word_count+1 == MAX_WORDS -> ERR; else address+1 -> LO.
REQ-016 write SHALL be high in WR only, exactly one completed write per word; no read ever issued.
REQ-017 Address increment SHALL wrap modulo 2^20 only if BASE_ADDR+MAX_WORDS exceeds 2^20; no other wrap.
REQ-018 busy=1 in LO, HI, WR; done=1 in DONE only; error=1 in ERR only; all registered.
REQ-019 Minimum throughput with waitrequest=0 and in_valid constant: one 16-bit word per 3 clocks.
REQ-020 in_last on the byte accepted in HI SHALL end the load after that full-word write; in_last in HI never produces a partial byteenable.
REQ-021 word_count SHALL hold its final value in DONE/ERR until next start.

Reset
REQ-022 reset_n=0 SHALL immediately force state IDLE, address=BASE_ADDR, byteenable=2'b00, writedata=0, write=0, in_ready=0, busy=0, done=0, error=0, word_count=0.
REQ-023 Reset asserted mid-WR SHALL drop write asynchronously; no write reissued after release; release returns to IDLE awaiting start.

Verification
REQ-024 start, bytes 11,22,33,44 (last on 44), waitrequest=0 -> writes addr 0 data 16'h2211 be 11, addr 1 data 16'h4433 be 11; done=1, word_count=2.
REQ-025 start, bytes AA,BB,CC (last on CC) -> second write addr 1 data 16'h00CC be 01; word_count=2; done=1.
REQ-026 waitrequest high 5 cycles during first write -> write, address, data stable 6 cycles, in_ready=0 throughout, single write completion counted.
REQ-027 MAX_WORDS=2, 6 bytes, no last until byte 6 -> 2 writes, state ERR after second, error=1, in_ready=0, bytes 5-6 not accepted.
REQ-028 reset_n pulsed low while write=1 -> write=0 same timestep, outputs at REQ-022 values; subsequent start reloads from BASE_ADDR.
REQ-029 start pulsed during HI -> ignored, load completes with unchanged address sequence.
